// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Handshaked immediate-extension stage between instruction decode and the
//   operand mux. It widens an IN_W-bit immediate to OUT_W bits using one of
//   four per-transaction modes. A main register (M) drives the outputs, and a
//   skid register (S) absorbs one extra result, so decode back-pressure never
//   drops an immediate.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   input transaction present
//   in_ready   stage can accept (registered, equals !S.valid outside reset)
//   in_data    raw IN_W-bit immediate
//   in_mode    00 zero-ext, 01 sign-ext MSB, 10 sign-ext from in_sbit,
//              11 sign-ext MSB then shift left by one
//   in_sbit    sign-bit index for mode 10 (clamped to IN_W-1)
//   out_valid  out_data holds a result
//   out_ready  consumer accepts
//   out_data   extended immediate
//   out_mode   mode of the transaction currently on out_data
//
// Occupancy
//   state | meaning
//   EMPTY | M empty, S empty
//   ONE   | M holds a result, S empty
//   FULL  | M and S both hold results, in_ready low
module imm_extend_pipe #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 16,
  parameter int SB_W  = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [SB_W-1:0]  in_sbit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] sext_msb;
  logic [SB_W-1:0]  sel;

  logic             s_valid;
  logic [OUT_W-1:0] s_data;
  logic [1:0]       s_mode;

  logic accept;
  logic consume;

  assign sext_msb = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

  // Clamp the runtime sign-bit index so an out-of-range index behaves as the MSB.
  always_comb begin
    sel = in_sbit;
    if (int'(in_sbit) > IN_W-1) sel = SB_W'(IN_W-1);
  end

  always_comb begin
    ext = '0;
    case (in_mode)
      2'b00: ext = {{(OUT_W-IN_W){1'b0}}, in_data};
      2'b01: ext = sext_msb;
      2'b10: begin
        for (int i = 0; i < OUT_W; i++) begin
          if (i <= int'(sel)) ext[i] = in_data[i];
          else                ext[i] = in_data[sel];
        end
      end
      default: ext = {sext_msb[OUT_W-2:0], 1'b0};
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
      s_valid   <= 1'b0;
      s_data    <= '0;
      s_mode    <= '0;
      in_ready  <= 1'b0;
    end else begin
      if (consume && s_valid) begin
        // FULL -> ONE: the skid entry moves up. in_ready was low, so no accept.
        out_data <= s_data;
        out_mode <= s_mode;
        s_valid  <= 1'b0;
        in_ready <= 1'b1;
      end else if (accept && (!out_valid || consume)) begin
        out_valid <= 1'b1;
        out_data  <= ext;
        out_mode  <= in_mode;
        in_ready  <= 1'b1;
      end else if (accept) begin
        // M is held by back-pressure, so the new result goes into the skid slot.
        s_valid  <= 1'b1;
        s_data   <= ext;
        s_mode   <= in_mode;
        in_ready <= 1'b0;
      end else begin
        if (consume) out_valid <= 1'b0;
        in_ready <= !s_valid;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  localparam int IN_W  = 10;
  localparam int OUT_W = 16;
  localparam int SB_W  = $clog2(IN_W);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic [SB_W-1:0]  in_sbit;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_sbit(in_sbit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [1:0]       m;
  } item_t;

  item_t q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: treat the immediate as a number and extend it arithmetically.
  function automatic logic [OUT_W-1:0] ref_ext(input int d, input int m, input int sb);
    int v, s, w, sx;
    sx = (d >= (1 << (IN_W-1))) ? d - (1 << IN_W) : d;
    case (m)
      0: v = d;
      1: v = sx;
      2: begin
        s = (sb > IN_W-1) ? IN_W-1 : sb;
        w = d % (1 << (s+1));
        v = (w >= (1 << s)) ? w - (1 << (s+1)) : w;
      end
      default: v = sx * 2;
    endcase
    return OUT_W'(v);
  endfunction

  // One clock with the inputs currently driven; the queue model tracks the stage.
  task automatic step();
    logic acc, cons;
    item_t it;
    acc  = in_valid && in_ready;
    cons = out_valid && out_ready;
    it.d = ref_ext(int'(in_data), int'(in_mode), int'(in_sbit));
    it.m = in_mode;
    @(posedge clk);
    #1;
    if (cons && q.size() > 0) void'(q.pop_front());
    if (acc) q.push_back(it);
    check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      check("out_data", {16'b0, out_data}, {16'b0, q[0].d});
      check("out_mode", {30'b0, out_mode}, {30'b0, q[0].m});
    end
    check("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
  endtask

  task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic [1:0] m,
                       input logic [SB_W-1:0] sb);
    in_valid = v; in_data = d; in_mode = m; in_sbit = sb;
  endtask

  // Directed mode vectors: data, mode, sbit, expected
  localparam int ND = 7;
  logic [IN_W-1:0]  dv_d [ND] = '{10'h200, 10'h200, 10'h100, 10'h2FF, 10'h3FF, 10'h1FF, 10'h200};
  logic [1:0]       dv_m [ND] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10};
  logic [SB_W-1:0]  dv_s [ND] = '{4'd0, 4'd0, 4'd8, 4'd8, 4'd0, 4'd0, 4'd15};
  logic [OUT_W-1:0] dv_e [ND] = '{16'h0200, 16'hFE00, 16'hFF00, 16'h00FF, 16'hFFFE, 16'h03FE, 16'hFE00};

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b1, 10'h155, 2'b01, 4'd0);

    // Reset held two cycles with a handshake offered.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", {16'b0, out_data}, 32'd0);
      check("rst_out_mode", {30'b0, out_mode}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);
    check("rel_out_valid", {31'b0, out_valid}, 32'd0);
    q.delete();
    drive(1'b0, '0, 2'b00, '0);
    step();

    // Mode coverage with fixed expected values, including the sbit clamp.
    for (int i = 0; i < ND; i++) begin
      drive(1'b1, dv_d[i], dv_m[i], dv_s[i]);
      step();
      check($sformatf("mode_vec%0d", i), {16'b0, out_data}, {16'b0, dv_e[i]});
      drive(1'b0, '0, 2'b00, '0);
      step();
    end

    // Back-pressure: A held, B in skid, C refused.
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, IN_W'(i), 2'b00, '0);
      step();
    end
    check("bp_hold_A", {16'b0, out_data}, 32'h0001);
    check("bp_ready_low", {31'b0, in_ready}, 32'd0);
    check("bp_depth", q.size(), 32'd2);
    drive(1'b0, 10'h3AA, 2'b11, 4'd3);   // idle input changes must not matter
    step();
    out_ready = 1'b1;
    step();
    check("bp_out_B", {16'b0, out_data}, 32'h0002);
    step();
    check("bp_drained", {31'b0, out_valid}, 32'd0);
    // Now offer C again, since it was never taken.
    drive(1'b1, 10'h003, 2'b00, '0);
    step();
    check("bp_out_C", {16'b0, out_data}, 32'h0003);
    drive(1'b0, '0, 2'b00, '0);
    step();

    // Full throughput: 16 back-to-back random transactions.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, IN_W'($urandom), 2'($urandom), SB_W'($urandom));
      step();
      check("tput_ready", {31'b0, in_ready}, 32'd1);
    end
    drive(1'b0, '0, 2'b00, '0);
    step();

    // Random traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), IN_W'($urandom), 2'($urandom), SB_W'($urandom));
      out_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end

    // Reset while FULL.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, IN_W'($urandom), 2'($urandom), SB_W'($urandom));
      step();
    end
    check("pre_rst_full", q.size(), 32'd2);
    rst = 1'b1;
    drive(1'b1, 10'h2AA, 2'b01, '0);
    @(posedge clk); #1;
    q.delete();
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rel_out_valid", {31'b0, out_valid}, 32'd0);
    drive(1'b1, 10'h1FF, 2'b11, '0);
    step();
    check("post_rst_first", {16'b0, out_data}, 32'h03FE);
    drive(1'b0, '0, 2'b00, '0);
    step();
    check("post_rst_drained", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
